// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  // Selects what the registered tx line shows next cycle.
  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_START,
    SEL_DATA,
    SEL_STOP
  } txSel_t;

  // Line level for a given selector; data bits come from the shift register LSB.
  function automatic logic lineLevel(input txSel_t sel, input logic dataBit);
    logic level;
    level = 1'b1;
    case (sel)
      SEL_START: level = 1'b0;
      SEL_DATA:  level = dataBit;
      default:   level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer for the UART transmitter: state, tick and bit counters.
// Produces the load/shift strobes and the line selector for the datapath.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic   clk,
  input  logic   arst,
  input  logic   brTick8x,
  input  logic   holdFull,
  output logic   loadEn,
  output logic   shiftEn,
  output txSel_t txSel,
  output logic   txBusy
);

  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  txState_t          state;
  logic [TICK_W-1:0] tickCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic              bitEnd;

  // A bit period ends on the tick that wraps the oversample counter.
  assign bitEnd  = brTick8x && (tickCnt == TICK_LAST);
  // Frames only start on a tick so the start bit is a full period long.
  assign loadEn  = (state == IDLE) && holdFull && brTick8x;
  assign shiftEn = (state == DATA) && bitEnd;

  // Frame sequencing: counters advance on ticks, state moves on bit ends.
  always_ff @(posedge clk) begin
    if (arst) begin
      state   <= IDLE;
      tickCnt <= '0;
      bitCnt  <= '0;
      txSel   <= SEL_IDLE;
      txBusy  <= 1'b0;
    end else begin
      if (brTick8x) begin
        tickCnt <= bitEnd ? '0 : tickCnt + TICK_W'(1);
      end
      case (state)
        IDLE: begin
          if (loadEn) begin
            state   <= START;
            tickCnt <= '0;
            bitCnt  <= '0;
            txSel   <= SEL_START;
            txBusy  <= 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            state  <= DATA;
            bitCnt <= '0;
            txSel  <= SEL_DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitCnt == DATA_LAST) begin
              state  <= STOP;
              bitCnt <= '0;
              txSel  <= SEL_STOP;
            end else begin
              bitCnt <= bitCnt + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (bitCnt == STOP_LAST) begin
              state  <= IDLE;
              bitCnt <= '0;
              txSel  <= SEL_IDLE;
              txBusy <= 1'b0;
            end else begin
              bitCnt <= bitCnt + BIT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          txSel  <= SEL_IDLE;
          txBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one-entry holding register in front of an 8N1 serializer.
// The datapath (holding/shift registers, tx flop) lives here; sequencing is in uart_tx_fsm.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 brTick8x,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  output logic                 tx,
  output logic                 txBusy
);

  logic [DATA_BITS-1:0] holdReg;
  logic                 holdFull;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 loadEn;
  logic                 shiftEn;
  txSel_t               txSel;

  assign txReady = !holdFull;

  uart_tx_fsm #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .STOP_BITS (STOP_BITS)
  ) txFsm (
    .clk     (clk),
    .arst    (arst),
    .brTick8x(brTick8x),
    .holdFull(holdFull),
    .loadEn  (loadEn),
    .shiftEn (shiftEn),
    .txSel   (txSel),
    .txBusy  (txBusy)
  );

  // Holding register: filled by the handshake, drained when a frame starts.
  // Fill and drain can never coincide because they need opposite holdFull values.
  always_ff @(posedge clk) begin
    if (arst) begin
      holdReg  <= '0;
      holdFull <= 1'b0;
    end else if (txValid && txReady) begin
      holdReg  <= txData;
      holdFull <= 1'b1;
    end else if (loadEn) begin
      holdFull <= 1'b0;
    end
  end

  // Shift register: loaded at frame start, shifted right once per data bit (LSB first).
  always_ff @(posedge clk) begin
    if (arst) begin
      shiftReg <= '0;
    end else if (loadEn) begin
      shiftReg <= holdReg;
    end else if (shiftEn) begin
      shiftReg <= shiftReg >> 1;
    end
  end

  // Registered line driver so tx is glitch-free; it lags the state by one clock.
  always_ff @(posedge clk) begin
    if (arst) begin
      tx <= 1'b1;
    end else begin
      tx <= lineLevel(txSel, shiftReg[0]);
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (one and two stop bits), a frame-level
// reference model compared every cycle, a behavioural receiver on instance 0,
// and directed scenarios with hand-computed literal expectations.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       brTick8x = 1'b0;
  logic       arst [2];
  logic [7:0] txData [2];
  logic       txValid [2];
  logic       txReady [2];
  logic       tx [2];
  logic       txBusy [2];

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  // Reference model state, one slot per instance.
  bit         mHold [2];
  bit         mActive [2];
  int         mTicks [2];
  logic [7:0] mHoldByte [2];
  logic [10:0] mFrame [2];
  logic       mLine [2];
  logic       expTx [2];
  logic       expBusy [2];
  logic       expReady [2];
  logic [7:0] sentQ [$];

  uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .arst(arst[0]), .brTick8x(brTick8x), .txData(txData[0]),
    .txValid(txValid[0]), .txReady(txReady[0]), .tx(tx[0]), .txBusy(txBusy[0])
  );

  uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(8), .STOP_BITS(2)) dut1 (
    .clk(clk), .arst(arst[1]), .brTick8x(brTick8x), .txData(txData[1]),
    .txValid(txValid[1]), .txReady(txReady[1]), .tx(tx[1]), .txBusy(txBusy[1])
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter and baud tick: the tick is sampled on every 4th rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    brTick8x = ((cyc % 4) == 3);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame-level model: a frame starts on the first tick seen while idle with a byte held,
  // lasts 8 ticks per bit for start + 8 data + stop bits, and the line shows that level
  // one clock later. Acceptance happens whenever the holding slot is empty.
  always @(posedge clk) begin
    logic prevLine;
    bit   accept;
    bit   load;
    int   nStop;
    for (int d = 0; d < 2; d++) begin
      nStop = (d == 0) ? 1 : 2;
      if (arst[d]) begin
        mHold[d] = 0; mActive[d] = 0; mTicks[d] = 0; mLine[d] = 1'b1;
        expTx[d] = 1'b1; expBusy[d] = 1'b0; expReady[d] = 1'b1;
        if (d == 0) sentQ.delete();
      end else begin
        prevLine = mLine[d];
        accept = txValid[d] && !mHold[d];
        load = mHold[d] && !mActive[d] && brTick8x;
        if (mActive[d] && brTick8x) begin
          mTicks[d]++;
          if (mTicks[d] == 8 * (9 + nStop)) mActive[d] = 0;
        end
        if (load) begin
          mFrame[d] = {2'b11, mHoldByte[d], 1'b0};
          mActive[d] = 1; mTicks[d] = 0; mHold[d] = 0;
        end
        if (accept) begin
          mHold[d] = 1; mHoldByte[d] = txData[d];
          if (d == 0) sentQ.push_back(txData[0]);
        end
        mLine[d] = mActive[d] ? mFrame[d][mTicks[d] / 8] : 1'b1;
        expTx[d] = prevLine;
        expBusy[d] = mActive[d];
        expReady[d] = !mHold[d];
      end
    end
  end

  // Every-cycle comparison of both instances against the model, away from the edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("tx%0d", d), 32'(tx[d]), 32'(expTx[d]));
        checkOutput($sformatf("txBusy%0d", d), 32'(txBusy[d]), 32'(expBusy[d]));
        checkOutput($sformatf("txReady%0d", d), 32'(txReady[d]), 32'(expReady[d]));
      end
    end
  end

  // Behavioural receiver on instance 0: detects the start edge, samples mid-bit
  // (16 clk into each 32 clk bit) and checks bytes against the accepted-byte queue.
  bit         rxActive = 0;
  int         rxOff = 0;
  logic [7:0] rxByte = '0;
  always @(negedge clk) begin
    int k;
    if (checkEn) begin
      if (arst[0]) begin
        rxActive = 0;
      end else if (!rxActive) begin
        if (tx[0] == 1'b0) begin
          rxActive = 1; rxOff = 0;
        end
      end else begin
        rxOff++;
        if ((rxOff % 32) == 16) begin
          k = rxOff / 32;
          if (k == 0) checkOutput("rxStartBit", 32'(tx[0]), 32'd0);
          else if (k <= 8) rxByte[k-1] = tx[0];
          else begin
            checkOutput("rxStopBit", 32'(tx[0]), 32'd1);
            if (sentQ.size() == 0) checkOutput("rxUnexpectedByte", 32'(rxByte), 32'h100);
            else checkOutput("rxByte", 32'(rxByte), 32'(sentQ.pop_front()));
            rxActive = 0;
          end
        end
      end
    end
  end

  // Offer one byte with txValid and hold it until the handshake completes.
  // Called from just after a rising edge; returns the edge number of the transfer.
  task automatic applyStimulus(input int d, input logic [7:0] b, output int accCyc);
    logic r;
    bit done;
    done = 0;
    accCyc = -1;
    txValid[d] = 1'b1;
    txData[d] = b;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      r = txReady[d];
      @(posedge clk);
      #1;
      if (r) begin
        done = 1; accCyc = cyc;
      end
    end
    checkOutput("acceptTimeout", 32'(done), 32'd1);
    txValid[d] = 1'b0;
  endtask

  // Watch one frame: falling-edge cycle, mid-bit samples, busy and ready-low cycle counts.
  task automatic observeFrame(input int d, output logic [10:0] bits, output int busyCnt,
                              output int fallAt, output int rdyLow);
    bit fallen, ended, seenReady;
    int idx;
    fallen = 0; ended = 0; seenReady = 0; idx = 0;
    bits = '1; busyCnt = 0; fallAt = -1; rdyLow = 0;
    for (int i = 0; i < 1000 && !ended; i++) begin
      @(negedge clk);
      if (!seenReady) begin
        if (txReady[d]) seenReady = 1;
        else rdyLow++;
      end
      if (txBusy[d]) busyCnt++;
      if (!fallen && tx[d] == 1'b0) begin
        fallen = 1; fallAt = cyc;
      end
      if (fallen && ((cyc - fallAt) % 32) == 16 && idx < 11) begin
        bits[idx] = tx[d]; idx++;
      end
      if (fallen && !txBusy[d]) ended = 1;
    end
    checkOutput("observeTimeout", 32'(ended), 32'd1);
  endtask

  // Hard stop in case something above fails to terminate.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCnt, totalCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    logic [10:0] b1, b2;
    int busy1, busy2, f1, f2, r1, r2, a1, a2, a3, n;
    for (int d = 0; d < 2; d++) begin
      arst[d] = 1'b1; txValid[d] = 1'b0; txData[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    arst[0] = 1'b0; arst[1] = 1'b0;
    checkEn = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("resetTx", 32'(tx[0]), 32'd1);
    checkOutput("resetBusy", 32'(txBusy[0]), 32'd0);
    checkOutput("resetReady", 32'(txReady[0]), 32'd1);
    checkOutput("resetTx1", 32'(tx[1]), 32'd1);

    // Single byte 0x55.
    @(posedge clk); #1;
    $display("[TB] single byte 0x55");
    applyStimulus(0, 8'h55, a1);
    observeFrame(0, b1, busy1, f1, r1);
    checkOutput("bits55", 32'(b1), 32'(11'b11010101010));
    checkOutput("busy55", 32'(busy1), 32'd320);
    checkOutput("readyLowWithin4", 32'(r1 >= 1 && r1 <= 4), 32'd1);
    checkOutput("fallLatency", 32'(f1 - a1 >= 1 && f1 - a1 <= 5), 32'd1);

    // Reset in the middle of a DATA period, then a clean frame.
    @(posedge clk); #1;
    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h00, a1);
    n = 0;
    while (tx[0] !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("abortFrameStarted", 32'(tx[0]), 32'd0);
    repeat (32 * 3 + 10) @(posedge clk);
    #1;
    arst[0] = 1'b1;
    @(posedge clk); #1;
    arst[0] = 1'b0;
    @(negedge clk);
    checkOutput("midResetTx", 32'(tx[0]), 32'd1);
    checkOutput("midResetBusy", 32'(txBusy[0]), 32'd0);
    checkOutput("midResetReady", 32'(txReady[0]), 32'd1);
    @(posedge clk); #1;
    applyStimulus(0, 8'h3C, a1);
    observeFrame(0, b1, busy1, f1, r1);
    checkOutput("bits3C", 32'(b1), 32'(11'b11001111000));

    // Back-to-back 0xA3 then 0x0F.
    @(posedge clk); #1;
    $display("[TB] back-to-back frames");
    fork
      begin applyStimulus(0, 8'hA3, a1); applyStimulus(0, 8'h0F, a2); end
      begin observeFrame(0, b1, busy1, f1, r1); observeFrame(0, b2, busy2, f2, r2); end
    join
    checkOutput("bitsA3", 32'(b1), 32'(11'b11101000110));
    checkOutput("bits0F", 32'(b2), 32'(11'b11000011110));
    checkOutput("secondAcceptAfterLoad", 32'(a2 - f1), 32'd0);
    checkOutput("interFrameGap", 32'(f2 - f1), 32'd324);

    // Holding register full: three bytes with txValid held.
    @(posedge clk); #1;
    $display("[TB] holding register stall");
    fork
      begin applyStimulus(0, 8'h11, a1); applyStimulus(0, 8'h22, a2); applyStimulus(0, 8'h33, a3); end
      begin observeFrame(0, b1, busy1, f1, r1); end
    join
    checkOutput("bits11", 32'(b1), 32'(11'b11000100010));
    checkOutput("holdSecondAccept", 32'(a2 - f1), 32'd0);
    checkOutput("holdThirdStall", 32'(a3 - f1), 32'd324);

    // Two stop bits on instance 1.
    @(posedge clk); #1;
    $display("[TB] two stop bits");
    fork
      begin applyStimulus(1, 8'hFF, a1); applyStimulus(1, 8'hFF, a2); end
      begin observeFrame(1, b1, busy1, f1, r1); observeFrame(1, b2, busy2, f2, r2); end
    join
    checkOutput("bitsFFstop2", 32'(b1), 32'(11'b11111111110));
    checkOutput("busyStop2", 32'(busy1), 32'd352);
    checkOutput("gapStop2", 32'(f2 - f1), 32'd356);

    // Loopback traffic into the receiver.
    @(posedge clk); #1;
    $display("[TB] loopback 64 bytes");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 8'($urandom_range(0, 255)), a1);
      n = $urandom_range(0, 3);
      if (n == 0) begin
        repeat ($urandom_range(1, 40)) begin @(posedge clk); #1; end
      end
    end
    n = 0;
    while ((sentQ.size() != 0 || txBusy[0] !== 1'b0) && n < 3000) begin
      @(negedge clk); n++;
    end
    checkOutput("loopbackDrained", 32'(sentQ.size()), 32'd0);
    checkOutput("finalIdleTx", 32'(tx[0]), 32'd1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
